// File: rtl/mw_writeback.sv
// M/W pipeline register with the write-back data path.
// Latches the M-stage results each cycle, extends load data and selects the GRF write data.
module mw_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [31:0] INSTR_M,
  input  logic [31:0] PC_M,
  input  logic [4:0]  A3_M,
  input  logic [31:0] ALU_M,
  input  logic [31:0] DMRD_M,
  input  logic [31:0] HILO_M,
  input  logic [31:0] CP0RD_M,
  input  logic        RFWr_W,
  input  logic [2:0]  RSel_W,
  output logic [31:0] INSTR_W,
  output logic [31:0] PC_W,
  output logic [4:0]  A3_W,
  output logic [31:0] WD_W,
  output logic        WE_W
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned OW = 6;

  localparam logic [DW-1:0] RESET_PC  = 32'h0000_3000;
  localparam logic [DW-1:0] LINK_OFS  = 32'd8;

  localparam logic [OW-1:0] OP_LW = 6'b100011;
  localparam logic [OW-1:0] OP_LH = 6'b100001;
  localparam logic [OW-1:0] OP_LB = 6'b100000;

  localparam logic [2:0] SEL_ALU  = 3'b000;
  localparam logic [2:0] SEL_LOAD = 3'b001;
  localparam logic [2:0] SEL_LINK = 3'b010;
  localparam logic [2:0] SEL_HILO = 3'b011;
  localparam logic [2:0] SEL_CP0  = 3'b100;

  logic [DW-1:0] alu_q;
  logic [DW-1:0] dmrd_q;
  logic [DW-1:0] hilo_q;
  logic [DW-1:0] cp0rd_q;

  logic [OW-1:0] opcode;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [DW-1:0] load_data;

  // Pipeline register: always advances; a flush turns the slot into a bubble but keeps the PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      INSTR_W <= '0;
      PC_W    <= RESET_PC;
      A3_W    <= '0;
      alu_q   <= '0;
      dmrd_q  <= '0;
      hilo_q  <= '0;
      cp0rd_q <= '0;
    end else if (Req) begin
      INSTR_W <= '0;
      PC_W    <= PC_M;
      A3_W    <= '0;
      alu_q   <= '0;
      dmrd_q  <= '0;
      hilo_q  <= '0;
      cp0rd_q <= '0;
    end else begin
      INSTR_W <= INSTR_M;
      PC_W    <= PC_M;
      A3_W    <= RW'(A3_M);
      alu_q   <= ALU_M;
      dmrd_q  <= DMRD_M;
      hilo_q  <= HILO_M;
      cp0rd_q <= CP0RD_M;
    end
  end

  assign opcode = INSTR_W[31:26];

  // Pick the addressed halfword (addr[0] ignored) and byte out of the aligned word.
  always_comb begin
    half_sel = dmrd_q[15:0];
    byte_sel = dmrd_q[7:0];
    if (alu_q[1]) begin
      half_sel = dmrd_q[31:16];
    end
    case (alu_q[1:0])
      2'b00:   byte_sel = dmrd_q[7:0];
      2'b01:   byte_sel = dmrd_q[15:8];
      2'b10:   byte_sel = dmrd_q[23:16];
      default: byte_sel = dmrd_q[31:24];
    endcase
  end

  // Sign-extend sub-word loads; everything else passes the whole word.
  always_comb begin
    load_data = dmrd_q;
    case (opcode)
      OP_LW:   load_data = dmrd_q;
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      default: load_data = dmrd_q;
    endcase
  end

  // Write-data mux; link address wraps naturally in 32 bits.
  always_comb begin
    WD_W = '0;
    case (RSel_W)
      SEL_ALU:  WD_W = alu_q;
      SEL_LOAD: WD_W = load_data;
      SEL_LINK: WD_W = DW'(PC_W + LINK_OFS);
      SEL_HILO: WD_W = hilo_q;
      SEL_CP0:  WD_W = cp0rd_q;
      default:  WD_W = '0;
    endcase
  end

  // $0 is hard-wired, so never enable a write to it.
  assign WE_W = RFWr_W & (A3_W != '0);

endmodule

// File: tb/tb_mw_writeback.sv
// Self-checking bench for mw_writeback: directed cases plus random traffic vs. a reference model.
module tb_mw_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [31:0] INSTR_M, PC_M, ALU_M, DMRD_M, HILO_M, CP0RD_M;
  logic [4:0]  A3_M;
  logic        RFWr_W;
  logic [2:0]  RSel_W;
  logic [31:0] INSTR_W, PC_W, WD_W;
  logic [4:0]  A3_W;
  logic        WE_W;

  int total = 0;
  int bad   = 0;

  // Reference model of what the W stage should be holding.
  logic [31:0] m_instr, m_pc, m_alu, m_dmrd, m_hilo, m_cp0;
  logic [4:0]  m_a3;

  mw_writeback dut (
    .clk(clk), .reset(reset), .Req(Req),
    .INSTR_M(INSTR_M), .PC_M(PC_M), .A3_M(A3_M), .ALU_M(ALU_M),
    .DMRD_M(DMRD_M), .HILO_M(HILO_M), .CP0RD_M(CP0RD_M),
    .RFWr_W(RFWr_W), .RSel_W(RSel_W),
    .INSTR_W(INSTR_W), .PC_W(PC_W), .A3_W(A3_W), .WD_W(WD_W), .WE_W(WE_W)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_wd(input logic [2:0] rsel);
    logic [31:0] v;
    logic [5:0]  op;
    int unsigned sh;
    op = m_instr[31:26];
    case (rsel)
      3'd0: return m_alu;
      3'd1: begin
        if (op == 6'b100000) begin
          sh = 8 * int'(m_alu[1:0]);
          v = (m_dmrd >> sh) & 32'hFF;
          return (v >= 32'd128) ? v - 32'd256 : v;
        end else if (op == 6'b100001) begin
          sh = m_alu[1] ? 16 : 0;
          v = (m_dmrd >> sh) & 32'hFFFF;
          return (v >= 32'd32768) ? v - 32'd65536 : v;
        end
        return m_dmrd;
      end
      3'd2: return m_pc + 32'd8;
      3'd3: return m_hilo;
      3'd4: return m_cp0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_instr = 0; m_pc = 32'h3000; m_a3 = 0;
    m_alu = 0; m_dmrd = 0; m_hilo = 0; m_cp0 = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge; sample at edge+1.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else if (Req) begin
      m_instr = 0; m_pc = PC_M; m_a3 = 0;
      m_alu = 0; m_dmrd = 0; m_hilo = 0; m_cp0 = 0;
    end else begin
      m_instr = INSTR_M; m_pc = PC_M; m_a3 = A3_M;
      m_alu = ALU_M; m_dmrd = DMRD_M; m_hilo = HILO_M; m_cp0 = CP0RD_M;
    end
    #1;
  endtask

  task automatic drive_m(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] a3,
                         input logic [31:0] alu, input logic [31:0] dmrd);
    INSTR_M = instr; PC_M = pc; A3_M = a3; ALU_M = alu; DMRD_M = dmrd;
    HILO_M = 32'hA5A5_0001; CP0RD_M = 32'hC0C0_0002;
  endtask

  task automatic test_reset();
    reset = 1'b1; Req = 1'b0; RFWr_W = 1'b0; RSel_W = 3'd0;
    drive_m(32'h2108_0001, 32'h0000_4000, 5'd9, 32'h11, 32'h22);
    model_reset();
    #2;
    total++; if (INSTR_W !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", INSTR_W, 32'd0); end
    total++; if (PC_W !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC_W, 32'h3000); end
    total++; if (A3_W !== 5'd0) begin bad++; $display("FAIL reset_a3 got=%h exp=%h", A3_W, 5'd0); end
    total++; if (WE_W !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", WE_W); end
    tick(); tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    total++; if (INSTR_W !== 32'h2108_0001 || PC_W !== 32'h4000 || A3_W !== 5'd9) begin
      bad++; $display("FAIL first_edge got instr=%h pc=%h a3=%0d exp instr=21080001 pc=4000 a3=9", INSTR_W, PC_W, A3_W);
    end
  endtask

  task automatic test_lw();
    drive_m(32'h8C08_0004, 32'h3004, 5'd8, 32'h0000_0004, 32'h1234_5678);
    tick();
    RSel_W = 3'b001; RFWr_W = 1'b1; #1;
    total++; if (WD_W !== 32'h1234_5678) begin bad++; $display("FAIL lw_wd got=%h exp=%h", WD_W, 32'h12345678); end
    total++; if (WE_W !== 1'b1) begin bad++; $display("FAIL lw_we got=%b exp=1", WE_W); end
    total++; if (A3_W !== 5'd8) begin bad++; $display("FAIL lw_a3 got=%0d exp=8", A3_W); end
  endtask

  task automatic test_lb_lh();
    drive_m(32'h8008_0003, 32'h3008, 5'd8, 32'h0000_0003, 32'h80FF_7F01);
    tick(); RSel_W = 3'b001; #1;
    total++; if (WD_W !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_b3 got=%h exp=%h", WD_W, 32'hFFFFFF80); end
    drive_m(32'h8008_0000, 32'h300C, 5'd8, 32'h0000_0000, 32'h80FF_7F01);
    tick(); #1;
    total++; if (WD_W !== 32'h0000_0001) begin bad++; $display("FAIL lb_b0 got=%h exp=%h", WD_W, 32'h1); end
    drive_m(32'h8408_0002, 32'h3010, 5'd8, 32'h0000_0002, 32'h7FFF_8000);
    tick(); #1;
    total++; if (WD_W !== 32'h0000_7FFF) begin bad++; $display("FAIL lh_hi got=%h exp=%h", WD_W, 32'h7FFF); end
    drive_m(32'h8408_0001, 32'h3014, 5'd8, 32'h0000_0001, 32'h7FFF_8000);
    tick(); #1;
    total++; if (WD_W !== 32'hFFFF_8000) begin bad++; $display("FAIL lh_lo got=%h exp=%h", WD_W, 32'hFFFF8000); end
  endtask

  task automatic test_jal();
    drive_m(32'h0C00_0C04, 32'h0000_3010, 5'd31, 32'h0, 32'h0);
    tick(); RSel_W = 3'b010; RFWr_W = 1'b1; #1;
    total++; if (WD_W !== 32'h0000_3018 || WE_W !== 1'b1) begin
      bad++; $display("FAIL jal_link got wd=%h we=%b exp wd=00003018 we=1", WD_W, WE_W);
    end
    drive_m(32'h0C00_0C04, 32'hFFFF_FFFC, 5'd31, 32'h0, 32'h0);
    tick(); #1;
    total++; if (WD_W !== 32'h0000_0004) begin bad++; $display("FAIL jal_wrap got=%h exp=%h", WD_W, 32'h4); end
  endtask

  task automatic test_zero_and_flush();
    drive_m(32'h0109_0020, 32'h3018, 5'd0, 32'h55, 32'h0);
    tick(); RSel_W = 3'b000; RFWr_W = 1'b1; #1;
    total++; if (WE_W !== 1'b0) begin bad++; $display("FAIL zero_reg_we got=%b exp=0", WE_W); end
    drive_m(32'h0109_5020, 32'h0000_3020, 5'd10, 32'h77, 32'h0);
    Req = 1'b1;
    tick(); Req = 1'b0; #1;
    total++; if (INSTR_W !== 32'd0 || A3_W !== 5'd0 || PC_W !== 32'h3020) begin
      bad++; $display("FAIL flush got instr=%h a3=%0d pc=%h exp instr=0 a3=0 pc=3020", INSTR_W, A3_W, PC_W);
    end
    total++; if (WD_W !== 32'd0 || WE_W !== 1'b0) begin
      bad++; $display("FAIL flush_data got wd=%h we=%b exp wd=0 we=0", WD_W, WE_W);
    end
  endtask

  task automatic test_async_reset();
    drive_m(32'h4008_6000, 32'h0000_3040, 5'd8, 32'h0, 32'h0);
    CP0RD_M = 32'hDEAD_BEEF;
    tick(); RSel_W = 3'b100; RFWr_W = 1'b1; #1;
    total++; if (WD_W !== 32'hDEAD_BEEF || WE_W !== 1'b1) begin
      bad++; $display("FAIL mfc0 got wd=%h we=%b exp wd=deadbeef we=1", WD_W, WE_W);
    end
    #1 reset = 1'b1;
    #1;
    total++; if (INSTR_W !== 32'd0 || WE_W !== 1'b0 || PC_W !== 32'h3000) begin
      bad++; $display("FAIL async_reset got instr=%h we=%b pc=%h exp instr=0 we=0 pc=3000", INSTR_W, WE_W, PC_W);
    end
    total++; if (WD_W !== 32'd0) begin bad++; $display("FAIL async_reset_wd got=%h exp=0", WD_W); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops [4];
    logic [5:0] op;
    logic [31:0] exp_wd;
    logic exp_we;
    ops[0] = 6'b100011; ops[1] = 6'b100001; ops[2] = 6'b100000; ops[3] = 6'b001000;
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      INSTR_M = {op, 26'($urandom)};
      PC_M = $urandom; A3_M = 5'($urandom); ALU_M = $urandom;
      DMRD_M = $urandom; HILO_M = $urandom; CP0RD_M = $urandom;
      Req = ($urandom_range(0, 7) == 0);
      tick();
      Req = 1'b0;
      RSel_W = 3'($urandom); RFWr_W = 1'($urandom);
      #1;
      exp_wd = model_wd(RSel_W);
      exp_we = RFWr_W && (m_a3 != 0);
      total++; if (INSTR_W !== m_instr || PC_W !== m_pc || A3_W !== m_a3) begin
        bad++; $display("FAIL rand_regs[%0d] got instr=%h pc=%h a3=%0d exp instr=%h pc=%h a3=%0d",
                        i, INSTR_W, PC_W, A3_W, m_instr, m_pc, m_a3);
      end
      total++; if (WD_W !== exp_wd || WE_W !== exp_we) begin
        bad++; $display("FAIL rand_wd[%0d] rsel=%0d got wd=%h we=%b exp wd=%h we=%b",
                        i, RSel_W, WD_W, WE_W, exp_wd, exp_we);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lh();
    test_jal();
    test_zero_and_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
